// File: rtl/chu_fade_pkg.sv
// Shared definitions for the V4_USER4 fade video core: FSM states,
// slot register map, CTRL bit positions and the full-scale blend level.
package chu_fade_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    HOLD = 2'd2,
    IN   = 2'd3
  } fade_state_t;

  // Slot register word offsets (addr[1:0])
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STEP   = 2'd1;
  localparam logic [1:0] REG_TARGET = 2'd2;
  localparam logic [1:0] REG_HOLD   = 2'd3;

  // CTRL register bit positions
  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_AUTO   = 2;
  localparam int unsigned CTRL_BYPASS = 3;

  // Level at which the pixel equals the target colour exactly
  localparam int unsigned LEVEL_MAX = 16;

endpackage

// File: rtl/chu_fade_blend.sv
// Single-channel pixel mix: so = (si*(MAX-level) + target*level) / MAX.
// Purely combinational; level 0 passes si, level MAX yields target.
module chu_fade_blend
  import chu_fade_pkg::*;
#(
  parameter int unsigned CD = 4,
  parameter int unsigned LW = 5
) (
  input  logic [CD-1:0] si,
  input  logic [CD-1:0] target,
  input  logic [LW-1:0] level,
  output logic [CD-1:0] so
);

  localparam int unsigned SW = CD + LW;
  localparam int unsigned SH = $clog2(LEVEL_MAX);

  logic [LW-1:0] inv_level;
  logic [SW-1:0] mix;

  // Weighted sum of source and target, truncated back to channel width
  always_comb begin
    inv_level = LW'(LEVEL_MAX) - level;
    mix       = SW'(si) * SW'(inv_level) + SW'(target) * SW'(level);
    so        = CD'(mix >> SH);
  end

endmodule

// File: rtl/chu_vga_fade_core.sv
// Video slot core V4_USER4: blends every pixel toward a programmable
// target colour by a 0..16 level that a frame-synchronous FSM walks
// through fade-out, optional hold, and fade-in. Zero pixel latency.
module chu_vga_fade_core
  import chu_fade_pkg::*;
#(
  parameter int unsigned CD = 12,
  parameter int unsigned LW = 5,
  parameter int unsigned FW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int unsigned  CW       = CD / 3;
  localparam logic [LW-1:0] LVL_TOP = LW'(LEVEL_MAX);

  // Register file
  logic [CD-1:0] target;
  logic [FW-1:0] step;
  logic [FW-1:0] hold;
  logic          auto_en;
  logic          bypass;

  // Bus decode
  logic          wr_en;
  logic [1:0]    reg_sel;
  logic          go_wr;
  logic [FW-1:0] wr_frames;

  // Frame tick
  logic          xy0;
  logic          xy0_d;
  logic          tick;

  // Fade FSM state and counters
  fade_state_t   state, state_n;
  logic [LW-1:0] level, level_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic [FW-1:0] hold_cnt, hold_cnt_n;
  logic          step_due;
  logic          hold_done;

  // Blended pixel before bypass selection
  logic [CD-1:0] blend_rgb;

  logic          unused_bits;

  // Slot write decode; only the two low address bits select a register
  always_comb begin
    wr_en     = cs & write;
    reg_sel   = addr[1:0];
    go_wr     = wr_en && (reg_sel == REG_CTRL) && wr_data[CTRL_GO];
    wr_frames = wr_data[FW-1:0];
  end

  assign unused_bits = ^{addr[13:2], wr_data[31:CD]};

  // Register file: CTRL flags, step period, target colour, hold length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target  <= '0;
      step    <= FW'(1);
      hold    <= '0;
      auto_en <= 1'b0;
      bypass  <= 1'b0;
    end else if (wr_en) begin
      unique case (reg_sel)
        REG_CTRL: begin
          auto_en <= wr_data[CTRL_AUTO];
          bypass  <= wr_data[CTRL_BYPASS];
        end
        REG_STEP:   step   <= (wr_frames == '0) ? FW'(1) : wr_frames;
        REG_TARGET: target <= wr_data[CD-1:0];
        REG_HOLD:   hold   <= wr_frames;
        default: ;
      endcase
    end
  end

  // Origin detect; x,y sit at the origin for several cycles while the
  // pixel stream is stalled, so only the first such cycle is a tick
  always_comb begin
    xy0  = (x == '0) && (y == '0);
    tick = xy0 & ~xy0_d;
  end

  // Delayed origin flag; resets high so an origin at reset release is no tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xy0_d <= 1'b1;
    else        xy0_d <= xy0;
  end

  // Fade FSM state, level and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      level     <= '0;
      frame_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      frame_cnt <= frame_cnt_n;
      hold_cnt  <= hold_cnt_n;
    end
  end

  // Fade FSM next state. A go write beats a coincident tick. The level
  // check happens both on entry to a tick (go toward an end already
  // reached) and right after a step lands on the end level, so the
  // FSM leaves OUT/IN on the same tick that reaches 16 or 0. The >=
  // compares let a shrunken STEP/HOLD fire on the next tick.
  always_comb begin
    state_n     = state;
    level_n     = level;
    frame_cnt_n = frame_cnt;
    hold_cnt_n  = hold_cnt;
    step_due    = (frame_cnt >= (step - FW'(1)));
    hold_done   = (hold_cnt >= hold);

    if (go_wr) begin
      state_n     = wr_data[CTRL_DIR] ? OUT : IN;
      frame_cnt_n = '0;
    end else if (tick) begin
      unique case (state)
        IDLE: ;
        OUT: begin
          if (level == LVL_TOP) begin
            state_n    = auto_en ? HOLD : IDLE;
            hold_cnt_n = '0;
          end else if (step_due) begin
            level_n     = level + LW'(1);
            frame_cnt_n = '0;
            if (level == LVL_TOP - LW'(1)) begin
              state_n    = auto_en ? HOLD : IDLE;
              hold_cnt_n = '0;
            end
          end else begin
            frame_cnt_n = frame_cnt + FW'(1);
          end
        end
        HOLD: begin
          if (hold_done) begin
            state_n     = IN;
            frame_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt + FW'(1);
          end
        end
        IN: begin
          if (level == '0) begin
            state_n = IDLE;
          end else if (step_due) begin
            level_n     = level - LW'(1);
            frame_cnt_n = '0;
            if (level == LW'(1)) state_n = IDLE;
          end else begin
            frame_cnt_n = frame_cnt + FW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // One blender per colour channel
  for (genvar c = 0; c < 3; c++) begin : g_ch
    chu_fade_blend #(
      .CD(CW),
      .LW(LW)
    ) u_blend (
      .si    (si_rgb[c*CW +: CW]),
      .target(target[c*CW +: CW]),
      .level (level),
      .so    (blend_rgb[c*CW +: CW])
    );
  end

  // Output select; bypass only affects the pixel, the FSM keeps running
  always_comb begin
    so_rgb = bypass ? si_rgb : blend_rgb;
  end

endmodule

// File: doc/chu_vga_fade_core.md
Name: chu_vga_fade_core

Overview:
- Video slot core for slot V4_USER4 in the daisy-chained pixel pipeline: si_rgb from the square sprite stage (V5), so_rgb to the ghost sprite stage (V3).
- Blends each pixel toward a programmable target colour by a 17-step level (0..16).
- The level is advanced by a frame-synchronous fade state machine: fade-out, hold, fade-in.
- Pixel path adds zero latency, so pipeline alignment of frame_start/inc is unchanged.

Parameters:
- CD, 12, colour depth; 3 channels of CD/3 bits each.
- LW, 5, level width; level range 0..16.
- FW, 8, width of the step and hold frame counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- x  input  11  current pixel column from frame counter.
- y  input  11  current pixel row from frame counter.
- cs  input  1  slot chip select.
- write  input  1  slot write strobe.
- addr  input  14  slot register word address; only addr[1:0] decoded.
- wr_data  input  32  slot write data.
- si_rgb  input  CD  upstream pixel.
- so_rgb  output  CD  blended pixel.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - level=0, state=IDLE, target=0, step=1, hold=0, auto=0, bypass=0, counters=0, xy0_d=1.
  - so_rgb follows si_rgb combinationally from reset onward.
- Register writes (cs&write), decoded on addr[1:0]:
  - 0 CTRL: bit0 go, bit1 dir (1=out toward target, 0=in toward source), bit2 auto, bit3 bypass.
  - 1 STEP: wr_data[FW-1:0] = frames per level step; value 0 is stored as 1.
  - 2 TARGET: wr_data[CD-1:0].
  - 3 HOLD: wr_data[FW-1:0] = frames to hold at level 16 before auto fade-in.
- Frame tick:
  - xy0 = (x==0 && y==0); xy0_d = registered xy0.
  - tick = xy0 & ~xy0_d, exactly one cycle per frame.
  - Required because x,y hold their value across stalled (inc=0) cycles.
- States: IDLE, OUT, HOLD, IN.
- CTRL write with go=1:
  - Enter OUT (dir=1) or IN (dir=0); frame_cnt cleared.
  - The current level is kept, with no jump. A go issued mid-fade reverses from the current level.
- OUT, on tick:
  - If frame_cnt==step-1: level+1 and frame_cnt=0; otherwise frame_cnt+1.
  - At level 16: go to HOLD if auto=1 (hold_cnt=0), else IDLE.
- HOLD, on tick:
  - hold_cnt+1; when hold_cnt==hold, go to IN.
  - hold=0 means fade-in starts on the first tick.
- IN: mirror of OUT, level-1. At level 0, go to IDLE.
- Saturation: level never exceeds 16 and never goes below 0. A go toward the level already reached goes to IDLE at the next tick.
- Simultaneous CTRL write and tick: the write wins. Counter is cleared and level is unchanged that cycle.
- STEP/TARGET/HOLD writes take effect immediately, including mid-fade. frame_cnt is not cleared; if frame_cnt ≥ new step-1, the step fires on the next tick.
- Blend, per channel c (4 bits):
  - o_c = (si_c*(16-L) + t_c*L) >> 4.
  - Products are 9 bits; the sum is ≤240 and fits in 8 bits; truncation toward zero.
  - L=0 gives exact pass-through; L=16 gives exact target.
- bypass=1: so_rgb=si_rgb. The FSM keeps running.
- Reset asserted mid-fade: immediate return to reset values, so output is pass-through in the same cycle.

Decomposition:
- Shared package chu_fade_pkg:
  - fade_state_t enum {IDLE, OUT, HOLD, IN}.
  - Register offsets REG_CTRL=0, REG_STEP=1, REG_TARGET=2, REG_HOLD=3.
  - CTRL bit indices; LEVEL_MAX=16.
- Sub-module chu_fade_blend: purely combinational per-pixel mix. Parameter CD; inputs si, target, level; output so. Reused for all three channels via generate.
- FSM, counters, register file and tick detection stay in the top.

Test Plan:
- Reset, then si_rgb=12'h5A3 → so_rgb=12'h5A3. Drive reset low during a fade → so_rgb=si_rgb the same cycle, level=0.
- TARGET=12'h000, STEP=2, CTRL=0x3, 40 frames with si=12'hFFF:
  - Level rises 1 per 2 ticks; at L=8 so=12'h777; at L=16 so=12'h000; state IDLE.
- Hold back-to-back stalls (x=y=0 held 5 cycles) → exactly one tick counted per frame.
- auto=1, HOLD=3, STEP=1:
  - Reaches L=16 after 16 ticks, holds 4 ticks, then descends to 0 after 16 more ticks; IDLE.
- Mid-fade reversal: at L=9 write CTRL=0x1 (dir=0) on the same cycle as a tick → L stays 9 that cycle, then 8 at the next tick.
- bypass=1 at L=16 with TARGET=12'hF00 → so=si. Clearing bypass → so=12'hF00.
